// File: rtl/vga_pixel_tx.sv
// vga_pixel_tx -- VGA timing generator with a two-stage pixel pipeline.
//
// Free-running horizontal/vertical counters drive a combinational fetch
// request (stage 0). The upstream source returns the colour for a request
// one clock later. That colour is captured once (stage 2) alongside the
// sync/enable flags, which are delayed through two registered stages. This
// keeps the sync, de and colour outputs aligned to the same pixel.
//
// Optional feature macro: VGA_PIXEL_TX_TEST_PATTERN_EN
//   When defined, the pattern_en input is added. While pattern_en=1 the
//   output colour comes from 8 vertical colour bars of 128 px each, and
//   rgb_in is ignored.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   pattern_en   in   colour-bar select (only with the macro)
//   req_valid    out  fetch request, high when the counter position is visible
//   req_x/req_y  out  requested column/row, 0 when not valid
//   rgb_in       in   {r,g,b} returned one clock after the request
//   hs, vs       out  horizontal/vertical sync (asserted level SYNC_ACTIVE)
//   de           out  display enable
//   r, g, b      out  pixel colour, 0 whenever de=0
//   frame_start  out  one-clock pulse with output pixel (0,0)
module vga_pixel_tx #(
  parameter int   H_ACTIVE    = 1024,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BP        = 160,
  parameter int   V_ACTIVE    = 768,
  parameter int   V_FP        = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BP        = 29,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  output logic        req_valid,
  output logic [10:0] req_x,
  output logic [9:0]  req_y,
  input  logic [11:0] rgb_in,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;

  // stage 0 (combinational)
  logic vis0, hs0, vs0, fs0;
  // stage 1
  logic hs1_q, vs1_q, de1_q, fs1_q;
  // stage 2 (drives the outputs)
  logic hs_q, vs_q, de_q, fs_q;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    hc_d = hc_q + 11'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    vis0      = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs0       = ((hc_q >= HS_BEGIN) && (hc_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs0       = ((vc_q >= VS_BEGIN) && (vc_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    fs0       = (hc_q == '0) && (vc_q == '0);
    req_valid = vis0;
    req_x     = vis0 ? hc_q : '0;
    req_y     = vis0 ? vc_q : '0;
  end

`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
  // Bar index travels with stage 1 so the pattern lines up with rgb_in timing.
  logic [2:0] bar1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bar1_q <= '0;
    else        bar1_q <= hc_q[9:7];
  end

  logic [11:0] bar_rgb;
  always_comb begin
    bar_rgb = 12'h000;
    case (bar1_q)
      3'd0: bar_rgb = 12'hFFF; // white
      3'd1: bar_rgb = 12'hFF0; // yellow
      3'd2: bar_rgb = 12'h0FF; // cyan
      3'd3: bar_rgb = 12'h0F0; // green
      3'd4: bar_rgb = 12'hF0F; // magenta
      3'd5: bar_rgb = 12'hF00; // red
      3'd6: bar_rgb = 12'h00F; // blue
      default: bar_rgb = 12'h000; // black
    endcase
  end

  always_comb begin
    rgb_d = 12'h000;
    if (de1_q) rgb_d = pattern_en ? bar_rgb : rgb_in;
  end
`else
  // Blanking is applied at capture so the output register already holds 0.
  always_comb begin
    rgb_d = de1_q ? rgb_in : 12'h000;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q <= ~SYNC_ACTIVE;
      vs1_q <= ~SYNC_ACTIVE;
      de1_q <= 1'b0;
      fs1_q <= 1'b0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs1_q <= hs0;
      vs1_q <= vs0;
      de1_q <= vis0;
      fs1_q <= fs0;
      hs_q  <= hs1_q;
      vs_q  <= vs1_q;
      de_q  <= de1_q;
      fs_q  <= fs1_q;
      rgb_q <= rgb_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];

endmodule

// File: tb/tb_vga_pixel_tx.sv
// Testbench for vga_pixel_tx. Instance a uses a shrunken timing
// (24 x 12 totals) so whole frames fit in a short run; instance b uses the
// default 1024x768 timing for line-level checks.
// Small timing: H 16/2/3/3 (hs low hc 18..20), V 8/1/2/1 (vs low vc 9..10),
// frame = 288 clk.
module tb_vga_pixel_tx;

  logic clk;
  logic rst_n;

  logic        rqv_a, rqv_b;
  logic [10:0] rqx_a, rqx_b;
  logic [9:0]  rqy_a, rqy_b;
  logic [11:0] rgb_a, rgb_b;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        pat_en;

  int tests;
  int fails;

  vga_pixel_tx #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE(1'b0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .req_valid(rqv_a), .req_x(rqx_a), .req_y(rqy_a), .rgb_in(rgb_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .r(r_a), .g(g_a), .b(b_a),
    .frame_start(fs_a)
  );

  vga_pixel_tx u_b (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
    .pattern_en(pat_en),
`endif
    .req_valid(rqv_b), .req_x(rqx_b), .req_y(rqy_b), .rgb_in(rgb_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .r(r_b), .g(g_b), .b(b_b),
    .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected output colour pipeline (1 and 2 ticks old requests)
  logic [11:0] ea1, ea2, eb1, eb2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: source model returns colour of the request seen before the edge.
  task automatic tick();
    logic [11:0] raw_a, raw_b;
    raw_a = {rqx_a[3:0], rqy_a[3:0], 4'h5};
    raw_b = {rqx_b[3:0], rqy_b[3:0], 4'h5};
    ea2 = ea1; ea1 = rqv_a ? raw_a : 12'h000;
    eb2 = eb1; eb1 = rqv_b ? raw_b : 12'h000;
    @(posedge clk); #1;
    rgb_a = raw_a;
    rgb_b = raw_b;
  endtask

  function automatic logic [11:0] bar(input int x);
    logic [11:0] t [8];
    t = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return t[(x >> 7) & 7];
  endfunction

  initial begin
    int col_err_a, col_err_b;
    int hs_low_a, vs_low_a, de_cnt_a, fs_cnt_a, fs_nde_a;
    int hs_low_b, de_cnt_b;
    int hs_f_a [2];
    int vs_f_a [2];
    int fs_t_a [2];
    int hs_f_b [2];
    int nh_a, nv_a, nf_a, nh_b;
    logic ph_a, pv_a, ph_b;
    logic found;

    tests = 0; fails = 0;
    col_err_a = 0; col_err_b = 0;
    hs_low_a = 0; vs_low_a = 0; de_cnt_a = 0; fs_cnt_a = 0; fs_nde_a = 0;
    hs_low_b = 0; de_cnt_b = 0;
    nh_a = 0; nv_a = 0; nf_a = 0; nh_b = 0;
    hs_f_a = '{0, 0}; vs_f_a = '{0, 0}; fs_t_a = '{0, 0}; hs_f_b = '{0, 0};
    rgb_a = '0; rgb_b = '0; pat_en = 1'b0;
    ea1 = '0; ea2 = '0; eb1 = '0; eb2 = '0;

    // reset with a real falling edge
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_de", de_a, 0);
    chk("rst_rgb", {r_a, g_a, b_a}, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_req_valid", rqv_a, 1);
    chk("rst_req_xy", {rqx_a, rqy_a}, 0);
    chk("rst_b_hs", hs_b, 1);

    #2 rst_n = 1'b1;
    ph_a = hs_a; pv_a = vs_a; ph_b = hs_b;
    for (int n = 1; n <= 2800; n++) begin
      tick();
      if (n >= 2) begin
        if ({r_a, g_a, b_a} !== ea2) col_err_a++;
        if ({r_b, g_b, b_b} !== eb2) col_err_b++;
      end
      if (n <= 577) begin
        if (!hs_a) hs_low_a++;
        if (!vs_a) vs_low_a++;
        if (de_a) de_cnt_a++;
        if (fs_a && !de_a) fs_nde_a++;
        if (ph_a && !hs_a && nh_a < 2) begin hs_f_a[nh_a] = n; nh_a++; end
        if (pv_a && !vs_a && nv_a < 2) begin vs_f_a[nv_a] = n; nv_a++; end
        if (fs_a) begin
          if (nf_a < 2) fs_t_a[nf_a] = n;
          nf_a++;
          fs_cnt_a++;
        end
      end
      if (n <= 1345) begin
        if (!hs_b) hs_low_b++;
        if (de_b) de_cnt_b++;
      end
      if (ph_b && !hs_b && nh_b < 2) begin hs_f_b[nh_b] = n; nh_b++; end
      ph_a = hs_a; pv_a = vs_a; ph_b = hs_b;

      if (n == 1) begin
        chk("first_edge_req_x", rqx_a, 1);
        chk("first_edge_de", de_a, 0);
      end
      if (n == 2) begin
        chk("px00_fs", fs_a, 1);
        chk("px00_de", de_a, 1);
        chk("px00_rgb", {r_a, g_a, b_a}, 12'h005);
      end
      if (n == 15) chk("a_last_vis", {rqv_a, rqx_a}, {1'b1, 11'd15});
      if (n == 16) chk("a_after_vis", rqv_a, 0);
      if (n == 287) chk("a_wrap_pre", rqv_a, 0);
      if (n == 288) chk("a_wrap_req", {rqv_a, rqx_a, rqy_a}, {1'b1, 21'd0});
      if (n == 1023) chk("b_last_vis", {rqv_b, rqx_b}, {1'b1, 11'd1023});
      if (n == 1024) chk("b_after_vis", rqv_b, 0);
    end

    chk("a_colour_errors", col_err_a, 0);
    chk("b_colour_errors", col_err_b, 0);
    chk("a_hs_fall0", hs_f_a[0], 20);
    chk("a_hs_fall1", hs_f_a[1], 44);
    chk("a_hs_low_2frames", hs_low_a, 72);
    chk("a_vs_fall0", vs_f_a[0], 218);
    chk("a_vs_fall1", vs_f_a[1], 506);
    chk("a_vs_low_2frames", vs_low_a, 96);
    chk("a_de_2frames", de_cnt_a, 256);
    chk("a_fs_count", fs_cnt_a, 2);
    chk("a_fs_t0", fs_t_a[0], 2);
    chk("a_fs_t1", fs_t_a[1], 290);
    chk("a_fs_without_de", fs_nde_a, 0);
    chk("b_hs_fall0", hs_f_b[0], 1050);
    chk("b_hs_fall1", hs_f_b[1], 2394);
    chk("b_hs_low_line", hs_low_b, 136);
    chk("b_de_line", de_cnt_b, 1024);

    // mid-frame reset at a visible position (10,5)
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (rqv_a && rqx_a == 11'd10 && rqy_a == 10'd5) found = 1'b1;
      else tick();
    end
    chk("rstA_reach", found, 1);
    chk("rstA_pre_de", de_a, 1);
    chk("rstA_pre_rgb", {r_a, g_a, b_a}, 12'h855);
    #2 rst_n = 1'b0;
    #1;
    chk("rstA_de", de_a, 0);
    chk("rstA_rgb", {r_a, g_a, b_a}, 0);
    chk("rstA_fs", fs_a, 0);
    chk("rstA_req", {rqv_a, rqx_a, rqy_a}, {1'b1, 21'd0});
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rstA_restart_x", rqx_a, 1);
    chk("rstA_restart_de0", de_a, 0);
    tick();
    chk("rstA_restart_fs", fs_a, 1);
    chk("rstA_restart_rgb", {r_a, g_a, b_a}, 12'h005);

    // mid-frame reset while both syncs are asserted
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (!hs_a && !vs_a) found = 1'b1;
      else tick();
    end
    chk("rstB_reach", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstB_hs", hs_a, 1);
    chk("rstB_vs", vs_a, 1);
    repeat (3) @(posedge clk);
`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
    pat_en = 1'b1;
`endif
    #3 rst_n = 1'b1;

`ifdef VGA_PIXEL_TX_TEST_PATTERN_EN
    for (int n = 1; n <= 1025; n++) begin
      tick();
      if (n == 2 || n == 129 || n == 130 || n == 257 || n == 898 || n == 1025)
        chk($sformatf("pattern_x%0d", n - 2), {r_b, g_b, b_b}, bar(n - 2));
    end
    pat_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
